nios_system_cpu_data_in_edge: RTL and testbench

//  Avalon-MM slave input port: the CPU-read counterpart of the 8-bit data_out PIO.

---
 rtl/nios_system_cpu_data_in_edge.sv | 167 ++++++++++++++++
 tb/tb_nios_system_cpu_data_in_edge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_cpu_data_in_edge.sv
// Avalon-MM input PIO: synchronised level readback, per-bit edge capture and maskable irq.
// Optional per-bit input debounce filter is enabled by defining DATA_IN_DEBOUNCE_EN.
module nios_system_cpu_data_in_edge #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] lvl_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [1:0]       mode_r;
    logic [1:0]       arm_r;

    logic             wr_s;
    logic             armed_s;
    logic [WIDTH-1:0] lvl_next_s;
    logic [WIDTH-1:0] prev_next_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] edge_next_s;

    logic unused_writedata;
    assign unused_writedata = ^writedata;

`ifdef DATA_IN_DEBOUNCE_EN
    localparam int DB_MAX = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CW     = $clog2(DB_MAX + 1);

    logic [CW-1:0] db_cnt_r      [WIDTH];
    logic [CW-1:0] db_cnt_next_s [WIDTH];

    // Debounce filter; while arming, lvl follows sync2 directly so reset-time levels settle silently.
    always_comb begin
        lvl_next_s = lvl_r;
        for (int i = 0; i < WIDTH; i++) begin
            db_cnt_next_s[i] = '0;
            if (!armed_s) begin
                lvl_next_s[i] = sync2_r[i];
            end else if (sync2_r[i] == lvl_r[i]) begin
                lvl_next_s[i] = lvl_r[i];
            end else if (db_cnt_r[i] == CW'(DB_MAX)) begin
                lvl_next_s[i] = sync2_r[i];
            end else begin
                db_cnt_next_s[i] = db_cnt_r[i] + CW'(1);
            end
        end
    end

    // Per-bit debounce counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_r[i] <= db_cnt_next_s[i];
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Without filtering the level is simply the synchroniser output.
    always_comb begin
        lvl_next_s = sync2_r;
    end
`endif

    // Bus decode, edge selection and W1C merge (a same-cycle set beats the clear).
    always_comb begin
        wr_s    = chipselect & ~write_n;
        armed_s = (arm_r == 2'd3);
        rise_s  = lvl_r & ~prev_r;
        fall_s  = ~lvl_r & prev_r;
        if (wr_s && (address == ADDR_EDGE)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        case (mode_r)
            2'd0:    sel_s = rise_s;
            2'd1:    sel_s = fall_s;
            2'd2:    sel_s = rise_s | fall_s;
            default: sel_s = '0;
        endcase
        if (armed_s) begin
            prev_next_s = lvl_r;
        end else begin
            // Keep prev equal to lvl while arming so no edge is seen once armed.
            sel_s       = '0;
            prev_next_s = lvl_next_s;
        end
        edge_next_s = (edge_r & ~clr_s) | sel_s;
    end

    // Input pipeline, arm counter and CSRs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            lvl_r   <= '0;
            prev_r  <= '0;
            mask_r  <= '0;
            edge_r  <= '0;
            mode_r  <= 2'(RESET_EDGE_MODE);
            arm_r   <= 2'd0;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
            lvl_r   <= lvl_next_s;
            prev_r  <= prev_next_s;
            edge_r  <= edge_next_s;
            if (!armed_s) begin
                arm_r <= arm_r + 2'd1;
            end else begin
                arm_r <= arm_r;
            end
            if (wr_s && (address == ADDR_MASK)) begin
                mask_r <= writedata[WIDTH-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_s && (address == ADDR_MODE)) begin
                mode_r <= writedata[1:0];
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Zero-wait read mux, not gated by chipselect.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = lvl_r;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_r;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_r;
            ADDR_MODE: readdata[1:0]       = mode_r;
            default:   readdata            = 32'h0000_0000;
        endcase
    end

    assign irq = |(edge_r & mask_r);

endmodule

// File: tb/tb_nios_system_cpu_data_in_edge.sv
// Directed self-checking bench for nios_system_cpu_data_in_edge (default parameters).
// Debounce-specific scenario is built when DATA_IN_DEBOUNCE_EN is defined.
module tb_nios_system_cpu_data_in_edge;

`ifdef DATA_IN_DEBOUNCE_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 0;
`endif
    localparam int SETTLE = 5 + DLY;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    nios_system_cpu_data_in_edge dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        in_port = 8'hFF;
        tick(3);
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rst_data: got %h expected %h", rd, 32'h0); end
        bus_read(2'd1, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rst_mask: got %h expected %h", rd, 32'h0); end
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rst_edge: got %h expected %h", rd, 32'h0); end
        bus_read(2'd3, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rst_mode: got %h expected %h", rd, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b expected 0", irq); end
        reset = 1'b0;
        tick(2);
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rel_data_early: got %h expected %h", rd, 32'h0); end
        tick(1);
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'hFF) begin failures++; $display("FAIL rel_data_c3: got %h expected %h", rd, 32'hFF); end
        tick(4 + DLY);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rel_edge_quiet: got %h expected %h", rd, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rel_irq: got %b expected 0", irq); end
    endtask

    task automatic test_rising;
        logic [31:0] rd;
        in_port = 8'h00;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rise_no_fall_cap: got %h expected %h", rd, 32'h0); end
        bus_write(2'd1, 32'h01);
        in_port = 8'h01;
        tick(3 + DLY);
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'h01) begin failures++; $display("FAIL rise_data: got %h expected %h", rd, 32'h01); end
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rise_edge_early: got %h expected %h", rd, 32'h0); end
        tick(1);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h01) begin failures++; $display("FAIL rise_edge: got %h expected %h", rd, 32'h01); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq: got %b expected 1", irq); end
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rise_w1c: got %h expected %h", rd, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rise_irq_clr: got %b expected 0", irq); end
    endtask

    task automatic test_modes;
        logic [31:0] rd;
        bus_write(2'd3, 32'h1);
        in_port = 8'h09;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL fall_no_rise_cap: got %h expected %h", rd, 32'h0); end
        in_port = 8'h01;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h08) begin failures++; $display("FAIL fall_edge: got %h expected %h", rd, 32'h08); end
        bus_write(2'd1, 32'h08);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL mask_on_irq: got %b expected 1", irq); end
        bus_write(2'd1, 32'h00);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL mask_off_irq: got %b expected 0", irq); end
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h08) begin failures++; $display("FAIL mask_off_edge: got %h expected %h", rd, 32'h08); end
        bus_write(2'd3, 32'h2);
        in_port = 8'h09;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h08) begin failures++; $display("FAIL any_bit3_kept: got %h expected %h", rd, 32'h08); end
        in_port = 8'h29;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h28) begin failures++; $display("FAIL any_rise5: got %h expected %h", rd, 32'h28); end
        bus_write(2'd2, 32'h20);
        in_port = 8'h09;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h28) begin failures++; $display("FAIL any_fall5: got %h expected %h", rd, 32'h28); end
        bus_write(2'd3, 32'h3);
        bus_write(2'd2, 32'hFF);
        in_port = 8'h00;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mode_off_edge: got %h expected %h", rd, 32'h0); end
        bus_read(2'd3, rd); checks++;
        if (rd !== 32'h3) begin failures++; $display("FAIL mode_readback: got %h expected %h", rd, 32'h3); end
    endtask

    task automatic test_set_beats_clear;
        logic [31:0] rd;
        bus_write(2'd3, 32'h0);
        bus_write(2'd2, 32'hFF);
        in_port = 8'h04;
        tick(3 + DLY);
        bus_write(2'd2, 32'h04);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h04) begin failures++; $display("FAIL set_wins: got %h expected %h", rd, 32'h04); end
        bus_write(2'd2, 32'h04);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL clear_after: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        bus_write(2'd3, 32'h2);
        in_port = 8'hFB;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'hFF) begin failures++; $display("FAIL mid_edge_all: got %h expected %h", rd, 32'hFF); end
        bus_write(2'd1, 32'hFF);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL mid_irq: got %b expected 1", irq); end
        reset = 1'b1;
        tick(1);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_edge: got %h expected %h", rd, 32'h0); end
        bus_read(2'd1, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_mask: got %h expected %h", rd, 32'h0); end
        bus_read(2'd3, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_mode: got %h expected %h", rd, 32'h0); end
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_rst_data: got %h expected %h", rd, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq: got %b expected 0", irq); end
        reset = 1'b0;
        tick(SETTLE);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL mid_rearm_edge: got %h expected %h", rd, 32'h0); end
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'hFB) begin failures++; $display("FAIL mid_rearm_data: got %h expected %h", rd, 32'hFB); end
    endtask

`ifdef DATA_IN_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] rd;
        logic        seen;
        in_port = 8'h00;
        tick(SETTLE);
        bus_write(2'd2, 32'hFF);
        seen    = 1'b0;
        in_port = 8'h02;
        tick(3);
        in_port = 8'h00;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            bus_read(2'd0, rd);
            if (rd[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL db_short_data: got %b expected 0", seen); end
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL db_short_edge: got %h expected %h", rd, 32'h0); end
        in_port = 8'h02;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 6) begin
                bus_read(2'd0, rd); checks++;
                if (rd !== 32'h0) begin failures++; $display("FAIL db_long_early: got %h expected %h", rd, 32'h0); end
                in_port = 8'h00;
            end
            if (k == 7) begin
                bus_read(2'd0, rd); checks++;
                if (rd !== 32'h02) begin failures++; $display("FAIL db_long_data: got %h expected %h", rd, 32'h02); end
            end
            if (k == 8) begin
                bus_read(2'd2, rd); checks++;
                if (rd !== 32'h02) begin failures++; $display("FAIL db_long_edge: got %h expected %h", rd, 32'h02); end
            end
        end
    endtask
`else
    task automatic test_short_pulse;
        logic [31:0] rd;
        in_port = 8'h00;
        tick(SETTLE);
        bus_write(2'd2, 32'hFF);
        in_port = 8'h02;
        tick(1);
        in_port = 8'h00;
        tick(6);
        bus_read(2'd2, rd); checks++;
        if (rd !== 32'h02) begin failures++; $display("FAIL pulse_edge: got %h expected %h", rd, 32'h02); end
        bus_read(2'd0, rd); checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL pulse_data: got %h expected %h", rd, 32'h0); end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        test_reset();
        test_rising();
        test_modes();
        test_set_beats_clear();
        test_reset_mid();
`ifdef DATA_IN_DEBOUNCE_EN
        test_debounce();
`else
        test_short_pulse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
